// File: rtl/instr_fetch_unit_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
// Level-held read request with a one-cycle data-valid strobe; no other flow control.
interface instr_fetch_unit_if #(
  parameter int WORD_W = 16
);
  logic              readM;
  logic [WORD_W-1:0] address;
  logic              inputReady;
  logic [WORD_W-1:0] data;

  modport master (
    output readM,
    output address,
    input  inputReady,
    input  data
  );

  modport slave (
    input  readM,
    input  address,
    output inputReady,
    output data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds PC/IR, issues one memory read per fetch_req, abandons after TIMEOUT wait cycles.
// readM from the request edge until inputReady; instr_valid the cycle after data; requests during WAIT dropped.
module instr_fetch_unit #(
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_req,
  input  logic                pc_load,
  input  logic [WORD_W-1:0]   pc_in,
  instr_fetch_unit_if.master  mem,
  output logic [WORD_W-1:0]   pc,
  output logic                instr_valid,
  output logic                busy,
  output logic                fetch_err,
  output logic [3:0]          opcode,
  output logic [1:0]          rs,
  output logic [1:0]          rt,
  output logic [1:0]          rd,
  output logic [5:0]          func,
  output logic [7:0]          imm,
  output logic [11:0]         target
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  ir, ir_nxt;
  logic [WORD_W-1:0]  pc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               pend_vld, pend_vld_nxt;
  logic [WORD_W-1:0]  pend_pc, pend_pc_nxt;
  logic               iv_nxt, err_nxt;
  logic               redirect;
  logic [WORD_W-1:0]  redirect_pc;

  // A pc_load on the completing edge is the newest redirect, so it beats the pending one.
  assign redirect    = pend_vld | pc_load;
  assign redirect_pc = pc_load ? pc_in : pend_pc;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    cnt_nxt      = cnt;
    pend_vld_nxt = pend_vld;
    pend_pc_nxt  = pend_pc;
    iv_nxt       = 1'b0;
    err_nxt      = fetch_err;
    case (state)
      IDLE: begin
        if (pc_load) pc_nxt = pc_in;
        if (fetch_req) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (pc_load) begin
          pend_vld_nxt = 1'b1;
          pend_pc_nxt  = pc_in;
        end
        if (mem.inputReady) begin
          state_nxt    = IDLE;
          ir_nxt       = mem.data;
          pc_nxt       = redirect ? redirect_pc : pc + WORD_W'(1);
          pend_vld_nxt = 1'b0;
          iv_nxt       = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nxt    = IDLE;
          pc_nxt       = redirect ? redirect_pc : pc;
          pend_vld_nxt = 1'b0;
          err_nxt      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      cnt         <= '0;
      pend_vld    <= 1'b0;
      pend_pc     <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      mem.readM   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      cnt         <= cnt_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_pc     <= pend_pc_nxt;
      instr_valid <= iv_nxt;
      fetch_err   <= err_nxt;
      mem.readM   <= (state_nxt == WAIT);
      busy        <= (state_nxt == WAIT);
    end
  end

  // PC only moves on leaving WAIT, so it is stable for the whole read.
  assign mem.address = pc;

  assign opcode = ir[15:12];
  assign rs     = ir[11:10];
  assign rt     = ir[9:8];
  assign rd     = ir[7:6];
  assign func   = ir[5:0];
  assign imm    = ir[7:0];
  assign target = ir[11:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_instr_fetch_unit;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = '0;
  logic        inputReady = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] pc;
  logic        instr_valid, busy, fetch_err;
  logic [3:0]  opcode;
  logic [1:0]  rs, rt, rd;
  logic [5:0]  func;
  logic [7:0]  imm;
  logic [11:0] target;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.WORD_W(16)) mem_bus ();
  assign mem_bus.inputReady = inputReady;
  assign mem_bus.data       = data;

  instr_fetch_unit #(.WORD_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
    .mem(mem_bus), .pc(pc), .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .func(func), .imm(imm), .target(target)
  );

  always #5 clk = ~clk;

  // Reference model: fetch in flight, cycles waited, architectural registers, last redirect seen mid-fetch.
  bit          m_wait, m_pend_vld, m_iv, m_err;
  int          m_waited;
  logic [15:0] m_pc, m_ir, m_pend;

  task automatic model_reset();
    m_wait = 0; m_pend_vld = 0; m_iv = 0; m_err = 0; m_waited = 0;
    m_pc = 16'h0000; m_ir = 16'h0000; m_pend = 16'h0000;
  endtask

  task automatic model_step();
    m_iv = 0;
    if (m_wait) begin
      if (pc_load) begin m_pend_vld = 1; m_pend = pc_in; end
      if (inputReady) begin
        m_ir = data;
        m_pc = m_pend_vld ? m_pend : 16'((32'(m_pc) + 1) % 65536);
        m_pend_vld = 0; m_wait = 0; m_iv = 1;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_wait = 0; m_err = 1;
          if (m_pend_vld) m_pc = m_pend;
          m_pend_vld = 0;
        end
      end
    end else begin
      if (pc_load) m_pc = pc_in;
      if (fetch_req) begin m_wait = 1; m_waited = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic apply_reset();
    fetch_req = 0; pc_load = 0; inputReady = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (mem_bus.readM !== 1'b0) begin errors++; $display("FAIL reset_readM got %b want 0", mem_bus.readM); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
    checks++; if ({instr_valid, fetch_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {instr_valid, fetch_err}); end
    checks++; if ({opcode, target} !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h want 0000", {opcode, target}); end
    tick();
    checks++; if (mem_bus.readM !== 1'b0) begin errors++; $display("FAIL idle_no_fetch got readM=%b want 0", mem_bus.readM); end
  endtask

  task automatic test_basic_fetch();
    fetch_req = 1; tick(); fetch_req = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_bus.readM, busy} !== 2'b11 || mem_bus.address !== 16'h0000) begin
        errors++; $display("FAIL basic_wait%0d readM=%b busy=%b addr=%h want 1 1 0000", i, mem_bus.readM, busy, mem_bus.address);
      end
      tick();
    end
    inputReady = 1; data = 16'h6A05; tick(); inputReady = 0; data = 16'hFFFF;
    checks++; if (instr_valid !== 1'b1 || mem_bus.readM !== 1'b0) begin errors++; $display("FAIL basic_done iv=%b readM=%b want 1 0", instr_valid, mem_bus.readM); end
    checks++; if ({opcode, rs, rt, rd, func} !== {4'h6, 2'd2, 2'd2, 2'd0, 6'h05}) begin
      errors++; $display("FAIL basic_decode op=%h rs=%0d rt=%0d rd=%0d func=%h want 6 2 2 0 05", opcode, rs, rt, rd, func);
    end
    checks++; if (imm !== 8'h05 || target !== 12'hA05) begin errors++; $display("FAIL basic_imm imm=%h target=%h want 05 a05", imm, target); end
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL basic_pc got %h want 0001", pc); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse iv=%b want 0", instr_valid); end
  endtask

  task automatic test_pc_wrap();
    pc_load = 1; pc_in = 16'hFFFF; tick(); pc_load = 0;
    checks++; if (pc !== 16'hFFFF || mem_bus.readM !== 1'b0) begin errors++; $display("FAIL wrap_load pc=%h readM=%b want ffff 0", pc, mem_bus.readM); end
    fetch_req = 1; tick(); fetch_req = 0;
    checks++; if (mem_bus.address !== 16'hFFFF || mem_bus.readM !== 1'b1) begin errors++; $display("FAIL wrap_addr addr=%h readM=%b want ffff 1", mem_bus.address, mem_bus.readM); end
    inputReady = 1; data = 16'h1234; tick(); inputReady = 0;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", pc); end
  endtask

  task automatic test_pending_redirect();
    pc_load = 1; pc_in = 16'h0010; fetch_req = 1; tick(); fetch_req = 0; pc_load = 0;
    checks++; if (mem_bus.address !== 16'h0010) begin errors++; $display("FAIL pend_fetch_addr got %h want 0010", mem_bus.address); end
    pc_load = 1; pc_in = 16'h0040; tick();
    pc_in = 16'h0050; tick(); pc_load = 0;
    checks++; if (pc !== 16'h0010 || mem_bus.address !== 16'h0010) begin errors++; $display("FAIL pend_hold pc=%h addr=%h want 0010 0010", pc, mem_bus.address); end
    inputReady = 1; data = 16'h2000; tick(); inputReady = 0;
    checks++; if (pc !== 16'h0050) begin errors++; $display("FAIL pend_pc got %h want 0050", pc); end
  endtask

  task automatic test_timeout();
    fetch_req = 1; tick(); fetch_req = 0;
    for (int i = 1; i < TIMEOUT; i++) tick();
    checks++; if (mem_bus.readM !== 1'b1) begin errors++; $display("FAIL timeout_early readM=%b want 1", mem_bus.readM); end
    tick();
    checks++; if (mem_bus.readM !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_abort readM=%b err=%b want 0 1", mem_bus.readM, fetch_err); end
    checks++; if (pc !== 16'h0050 || instr_valid !== 1'b0 || {opcode, target} !== 16'h2000) begin
      errors++; $display("FAIL timeout_state pc=%h iv=%b ir=%h want 0050 0 2000", pc, instr_valid, {opcode, target});
    end
    fetch_req = 1; tick(); fetch_req = 0;
    inputReady = 1; data = 16'hC3C3; tick(); inputReady = 0;
    checks++; if (pc !== 16'h0051 || instr_valid !== 1'b1 || {opcode, target} !== 16'hC3C3 || fetch_err !== 1'b1) begin
      errors++; $display("FAIL timeout_recover pc=%h iv=%b ir=%h err=%b want 0051 1 c3c3 1", pc, instr_valid, {opcode, target}, fetch_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    fetch_req = 1; tick(); fetch_req = 0;
    tick(); tick();
    reset_n = 0; model_reset(); #1;
    checks++; if (mem_bus.readM !== 1'b0 || pc !== 16'h0000 || {opcode, target} !== 16'h0000 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL rst_wait readM=%b pc=%h ir=%h err=%b want 0 0000 0000 0", mem_bus.readM, pc, {opcode, target}, fetch_err);
    end
    tick(); reset_n = 1;
    inputReady = 1; data = 16'hBEEF; tick(); tick(); inputReady = 0;
    checks++; if (instr_valid !== 1'b0 || {opcode, target} !== 16'h0000 || mem_bus.readM !== 1'b0) begin
      errors++; $display("FAIL rst_stray iv=%b ir=%h readM=%b want 0 0000 0", instr_valid, {opcode, target}, mem_bus.readM);
    end
  endtask

  task automatic test_random_traffic();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      fetch_req  = ($urandom_range(0, 3) == 0);
      pc_load    = ($urandom_range(0, 7) == 0);
      pc_in      = 16'($urandom);
      inputReady = ($urandom_range(0, 5) == 0);
      data       = 16'($urandom);
      tick();
      checks++; if (mem_bus.readM !== m_wait || busy !== m_wait) begin errors++; $display("FAIL rnd_readM c=%0d readM=%b busy=%b want %b", c, mem_bus.readM, busy, m_wait); end
      checks++; if (m_wait && mem_bus.address !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, mem_bus.address, m_pc); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc c=%0d got %h want %h", c, pc, m_pc); end
      checks++; if (instr_valid !== m_iv || fetch_err !== m_err) begin errors++; $display("FAIL rnd_flags c=%0d iv=%b err=%b want %b %b", c, instr_valid, fetch_err, m_iv, m_err); end
      checks++; if ({opcode, target} !== m_ir || {rs, rt} !== m_ir[11:8] || {rd, func} !== m_ir[7:0] || imm !== m_ir[7:0]) begin
        errors++; $display("FAIL rnd_ir c=%0d got %h want %h", c, {opcode, target}, m_ir);
      end
    end
    fetch_req = 0; pc_load = 0; inputReady = 0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_pc_wrap();
    test_pending_redirect();
    test_timeout();
    test_reset_mid_wait();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter WORD_W, default 16, SHALL set the width of instruction words and PC.
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum number of WAIT-state cycles before a fetch is abandoned.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_req  in  1  one-cycle fetch request from the control unit, issued on IF_1 entry.
REQ-006 pc_load  in  1  load PC from pc_in (branch/jump redirect).
REQ-007 pc_in  in  16  new PC value.
REQ-008 inputReady  in  1  memory read-data-valid strobe.
REQ-009 data  in  16  memory read data.
REQ-010 readM  out  1  memory read request.
REQ-011 address  out  16  memory address; SHALL equal PC whenever readM=1.
REQ-012 pc  out  16  current PC.
REQ-013 instr_valid  out  1  one-cycle pulse: new instruction latched in IR.
REQ-014 busy  out  1  high while in WAIT.
REQ-015 fetch_err  out  1  sticky timeout flag.
REQ-016 opcode[3:0], rs[1:0], rt[1:0], rd[1:0], func[5:0], imm[7:0], target[11:0]  out  decoded fields: IR[15:12], IR[11:10], IR[9:8], IR[7:6], IR[5:0], IR[7:0], IR[11:0]; combinational from IR.

Function
REQ-017 FSM states SHALL be IDLE and WAIT only; readM and busy SHALL be registered and high exactly while in WAIT.
REQ-018 IDLE, fetch_req=1 at an edge -> WAIT, wait counter cleared to 0; if pc_load=1 at that same edge, PC<=pc_in and the fetch SHALL use pc_in.
REQ-019 IDLE, pc_load=1, fetch_req=0 -> PC<=pc_in, stay IDLE.
REQ-020 WAIT, inputReady=1 at an edge -> IR<=data, PC<=PC+1 (modulo 2^16, 0xFFFF wraps to 0x0000), instr_valid=1 for exactly the next cycle, -> IDLE.
REQ-021 WAIT, inputReady=0 at an edge -> wait counter +1; when the counter reaches TIMEOUT -> IDLE, fetch_err<=1, IR and PC unchanged, instr_valid stays 0.
REQ-022 fetch_req in WAIT SHALL be ignored (no queueing).
REQ-023 pc_load in WAIT SHALL be captured in a pending register (last value wins); on fetch completion PC<=pending value instead of PC+1, pending cleared; on timeout PC<=pending value, pending cleared.
REQ-024 inputReady in IDLE SHALL be ignored; IR SHALL not change.
REQ-025 fetch_err SHALL clear only on reset; fetches SHALL continue normally after it is set.
REQ-026 Latency: fetch_req at edge T -> readM high from T; with inputReady at edge T+k (k>=1) -> instr_valid high in cycle after T+k, readM low from T+k.

Reset
REQ-027 reset_n=0 SHALL immediately force: state IDLE, PC=0x0000, IR=0x0000, readM=0, busy=0, instr_valid=0, fetch_err=0, wait counter=0, pending cleared.
REQ-028 Reset asserted mid-WAIT SHALL abandon the fetch; no IR write, no instr_valid on release.
REQ-029 After reset_n rises, no fetch SHALL start until fetch_req is seen.

Verification
REQ-030 Reset, fetch_req, memory returns data=0x6A05 with inputReady 4 cycles later -> address=0x0000 during WAIT, opcode=0x6, rs=2, rt=2, rd=0, func=0x05, PC=0x0001, one instr_valid pulse.
REQ-031 pc_load with pc_in=0xFFFF, fetch, data returned -> address=0xFFFF, PC wraps to 0x0000.
REQ-032 Fetch at PC=0x0010, pc_load pc_in=0x0040 during WAIT, then pc_load pc_in=0x0050, inputReady -> PC=0x0050, not 0x0011.
REQ-033 Fetch with inputReady never asserted -> after 8 WAIT cycles readM=0, fetch_err=1, PC unchanged; next fetch completes normally, fetch_err stays 1.
REQ-034 reset_n pulsed low 2 cycles into WAIT -> readM=0 at once, PC=0x0000, IR=0x0000, no instr_valid; stray inputReady in IDLE leaves IR unchanged.
